tmr_vote_monitor: RTL and testbench
===================================

Name: tmr_vote_monitor

Overview:
- Downstream stage of the triplicated 4-bit universal register.
- Consumes the three replica state words and produces a registered bitwise-majority word.
- Tracks per-replica mismatch statistics and declares a replica faulty after persistent disagreement.
- Runs a request/acknowledge scrub handshake so the register top can resynchronise the faulty replica from the voted value.

Parameters:
- WIDTH, 4: replica and voted word width.
- PERSIST, 3: consecutive enabled mismatch cycles needed to declare a replica faulty (legal range 1..15).
- CNT_W, 8: width of each saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  monitor/vote update enable.
- rep_a_data  in  WIDTH  replica A word.
- rep_b_data  in  WIDTH  replica B word.
- rep_c_data  in  WIDTH  replica C word.
- clr_counts  in  1  synchronous clear of counters and fault flags.
- scrub_ack  in  1  register top has reloaded the selected replica.
- voted_out  out  WIDTH  registered bitwise majority.
- mismatch  out  3  registered per-replica disagreement, bit0=A, bit1=B, bit2=C.
- uncorrectable  out  1  registered flag: all three replicas pairwise different.
- err_count_a  out  CNT_W  saturating mismatch count, replica A.
- err_count_b  out  CNT_W  saturating mismatch count, replica B.
- err_count_c  out  CNT_W  saturating mismatch count, replica C.
- faulty  out  3  sticky per-replica fault flags.
- scrub_req  out  1  scrub request.
- scrub_sel  out  3  one-hot replica to scrub; 0 when idle.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs, counters, persistence counters and FSM state go to 0/IDLE.
  - scrub_req drops immediately, even mid-handshake.
- Vote path:
  - maj = (a&b)|(a&c)|(b&c), computed bitwise.
  - If enable=1, voted_out <= maj. Latency is 1 cycle.
  - If enable=0, voted_out holds its value.
- mismatch[i]:
  - If enable=1, mismatch[i] <= (rep_i != maj).
  - If enable=0, mismatch is forced to 0.
- uncorrectable:
  - If enable=1, uncorrectable <= (a!=b) & (b!=c) & (a!=c).
  - If enable=0, uncorrectable holds.
- Error counters:
  - Increment when enable=1 and rep_i != maj.
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_counts has priority over increment.
- Persistence counters (4-bit, one per replica):
  - Increment while enable=1 and the replica mismatches.
  - Reset to 0 on a matching enabled cycle.
  - Hold while enable=0.
  - When a counter reaches PERSIST, set faulty[i]. The flag is visible on the same edge the counter reaches PERSIST.
- faulty[i] clears only when:
  - its scrub completes (DONE state), or
  - clr_counts=1.
- Scrub FSM (runs independently of enable):
  - IDLE: if faulty != 0 and uncorrectable=0, go to REQ. scrub_sel = lowest-index set faulty bit, latched on entry to REQ.
  - REQ: scrub_req=1 and scrub_sel held stable until scrub_ack=1, then go to DONE.
  - DONE (1 cycle): scrub_req=0; clear faulty and the persistence counter of the scrubbed replica; go to IDLE.
  - Error counters are NOT cleared by a scrub.
- FSM boundary conditions:
  - scrub_ack in IDLE or DONE is ignored.
  - If uncorrectable asserts while in REQ, the request is held; it is not withdrawn.
  - clr_counts during REQ clears faulty but the handshake still completes.
  - Multiple faulty replicas are serviced one per handshake in A, B, C order.

Test Plan:
1. Reset, then a=b=c=4'b0110 with enable=1 -> next cycle voted_out=0110, mismatch=000, all counts 0, scrub_req=0.
2. Force rep_c=4'b1111 for 1 cycle with a=b=0110 -> voted_out=0110, mismatch=100 for 1 cycle, err_count_c=1, faulty=000.
3. Hold rep_b=4'b0011 with a=c=0111 for 3 cycles -> faulty=010 on the 3rd edge; next cycle scrub_req=1, scrub_sel=010. Assert scrub_ack -> DONE -> faulty=000, scrub_req=0, err_count_b=3.
4. a=0001, b=0010, c=0100 -> voted_out=0000, uncorrectable=1, mismatch=111. No scrub_req even after PERSIST cycles, although faulty=111.
5. Drive err_count_a to 255, then keep A mismatching -> count stays 255. Pulse clr_counts together with a mismatch -> count=0, faulty=000.
6. Assert rst=0 while scrub_req=1 -> scrub_req, voted_out and counters go to 0 asynchronously. After release, FSM is in IDLE.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
// Majority voter and health monitor for a triplicated register: votes the three
// replica words, counts disagreements, flags persistent faults and drives a scrub handshake.
module tmr_vote_monitor #(
  parameter int WIDTH   = 4,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] rep_a_data,
  input  logic [WIDTH-1:0] rep_b_data,
  input  logic [WIDTH-1:0] rep_c_data,
  input  logic             clr_counts,
  input  logic             scrub_ack,
  output logic [WIDTH-1:0] voted_out,
  output logic [2:0]       mismatch,
  output logic             uncorrectable,
  output logic [CNT_W-1:0] err_count_a,
  output logic [CNT_W-1:0] err_count_b,
  output logic [CNT_W-1:0] err_count_c,
  output logic [2:0]       faulty,
  output logic             scrub_req,
  output logic [2:0]       scrub_sel
);

  localparam logic [3:0]       PERSIST_L  = 4'(PERSIST);
  localparam logic [3:0]       PERSIST_M1 = 4'(PERSIST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Run-length counter stops at PERSIST so a long fault never wraps it.
  function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
    return (v >= PERSIST_L) ? v : v + 4'd1;
  endfunction

  logic [WIDTH-1:0] w_rep [3];
  logic [WIDTH-1:0] w_maj;
  logic [2:0]       w_mis_now;
  logic             w_uncorr_now;
  logic [CNT_W-1:0] w_err [3];
  logic [2:0]       w_faulty;
  logic [2:0]       w_lowest;
  logic [2:0]       w_scrub_clr;
  logic             w_scrub_req;
  state_t           w_state_nxt;
  logic [2:0]       w_sel_nxt;

  logic [WIDTH-1:0] r_voted_p1;
  logic [2:0]       r_mis_p1;
  logic             r_uncorr_p1;
  state_t           r_state;
  logic [2:0]       r_sel;

  assign w_rep[0] = rep_a_data;
  assign w_rep[1] = rep_b_data;
  assign w_rep[2] = rep_c_data;

  assign w_maj = (rep_a_data & rep_b_data) | (rep_a_data & rep_c_data) |
                 (rep_b_data & rep_c_data);

  assign w_mis_now[0] = (rep_a_data != w_maj);
  assign w_mis_now[1] = (rep_b_data != w_maj);
  assign w_mis_now[2] = (rep_c_data != w_maj);

  assign w_uncorr_now = (rep_a_data != rep_b_data) && (rep_b_data != rep_c_data) &&
                        (rep_a_data != rep_c_data);

  // ---- stage p1: registered vote and disagreement flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_voted_p1  <= '0;
      r_mis_p1    <= 3'b000;
      r_uncorr_p1 <= 1'b0;
    end else begin
      if (enable) begin
        r_voted_p1  <= w_maj;
        r_uncorr_p1 <= w_uncorr_now;
      end
      r_mis_p1 <= enable ? w_mis_now : 3'b000;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rep
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_run;
    logic             r_flt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_err <= '0;
      end else if (clr_counts) begin
        r_err <= '0;
      end else if (enable && w_mis_now[g]) begin
        r_err <= sat_inc_err(r_err);
      end
    end

    // A finished scrub wipes the run history of the reloaded replica.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_run <= 4'd0;
        r_flt <= 1'b0;
      end else if (clr_counts || w_scrub_clr[g]) begin
        r_run <= 4'd0;
        r_flt <= 1'b0;
      end else if (enable) begin
        if (w_mis_now[g]) begin
          r_run <= sat_inc_run(r_run);
          if (r_run >= PERSIST_M1) begin
            r_flt <= 1'b1;
          end
        end else begin
          r_run <= 4'd0;
        end
      end
    end

    assign w_err[g]    = r_err;
    assign w_faulty[g] = r_flt;
  end

  // Isolate the lowest set fault bit so replicas are serviced A, B, C in turn.
  assign w_lowest = w_faulty & (~w_faulty + 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_scrub_clr = 3'b000;
    w_scrub_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_faulty != 3'b000) && !r_uncorr_p1) begin
          w_state_nxt = ST_REQ;
          w_sel_nxt   = w_lowest;
        end
      end
      ST_REQ: begin
        w_scrub_req = 1'b1;
        if (scrub_ack) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_scrub_clr = r_sel;
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 3'b000;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 3'b000;
      end
    endcase
  end

  assign voted_out     = r_voted_p1;
  assign mismatch      = r_mis_p1;
  assign uncorrectable = r_uncorr_p1;
  assign err_count_a   = w_err[0];
  assign err_count_b   = w_err[1];
  assign err_count_c   = w_err[2];
  assign faulty        = w_faulty;
  assign scrub_req     = w_scrub_req;
  assign scrub_sel     = r_sel;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the voter/monitor.
module tb_tmr_vote_monitor;
  localparam int WIDTH   = 4;
  localparam int PERSIST = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             clr_counts = 1'b0;
  logic             scrub_ack = 1'b0;
  logic [WIDTH-1:0] rep_a = '0;
  logic [WIDTH-1:0] rep_b = '0;
  logic [WIDTH-1:0] rep_c = '0;

  logic [WIDTH-1:0] voted_out;
  logic [2:0]       mismatch;
  logic             uncorrectable;
  logic [CNT_W-1:0] err_count_a, err_count_b, err_count_c;
  logic [2:0]       faulty;
  logic             scrub_req;
  logic [2:0]       scrub_sel;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  tmr_vote_monitor #(.WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rep_a_data(rep_a), .rep_b_data(rep_b), .rep_c_data(rep_c),
    .clr_counts(clr_counts), .scrub_ack(scrub_ack),
    .voted_out(voted_out), .mismatch(mismatch), .uncorrectable(uncorrectable),
    .err_count_a(err_count_a), .err_count_b(err_count_b), .err_count_c(err_count_c),
    .faulty(faulty), .scrub_req(scrub_req), .scrub_sel(scrub_sel)
  );

  always #5 clk = ~clk;

  // Behavioural model: run lengths are unbounded integers, the handshake is two flags.
  int m_voted, m_mis, m_unc;
  int m_cnt [3];
  int m_run [3];
  bit m_flt [3];
  bit m_req, m_done;
  int m_sel;

  function automatic int majority(input int a, input int b, input int c);
    int r = 0;
    for (int k = 0; k < WIDTH; k++) begin
      if ((((a >> k) & 1) + ((b >> k) & 1) + ((c >> k) & 1)) >= 2) r |= (1 << k);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_voted = 0; m_mis = 0; m_unc = 0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_run[i] = 0; m_flt[i] = 1'b0;
    end
    m_req = 1'b0; m_done = 1'b0; m_sel = -1;
  endtask

  task automatic model_step();
    int word [3];
    int mj;
    bit flt_old [3];
    int unc_old;
    int clr_idx;
    bit bad;
    word[0] = int'(rep_a); word[1] = int'(rep_b); word[2] = int'(rep_c);
    mj = majority(word[0], word[1], word[2]);
    flt_old = m_flt;
    unc_old = m_unc;
    clr_idx = m_done ? m_sel : -1;
    if (enable) begin
      m_voted = mj;
      m_unc = ((word[0] != word[1]) && (word[1] != word[2]) && (word[0] != word[2])) ? 1 : 0;
    end
    m_mis = 0;
    for (int i = 0; i < 3; i++) begin
      bad = enable && (word[i] != mj);
      if (bad) m_mis |= (1 << i);
      if (clr_counts) m_cnt[i] = 0;
      else if (bad && m_cnt[i] < CNT_SAT) m_cnt[i]++;
      if (clr_counts || i == clr_idx) begin
        m_run[i] = 0; m_flt[i] = 1'b0;
      end else if (enable) begin
        if (word[i] != mj) begin
          m_run[i]++;
          if (m_run[i] >= PERSIST) m_flt[i] = 1'b1;
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (m_done) begin
      m_done = 1'b0; m_sel = -1;
    end else if (m_req) begin
      if (scrub_ack) begin m_req = 1'b0; m_done = 1'b1; end
    end else if ((flt_old[0] || flt_old[1] || flt_old[2]) && unc_old == 0) begin
      m_req = 1'b1;
      m_sel = flt_old[0] ? 0 : (flt_old[1] ? 1 : 2);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("voted_out", int'(voted_out), m_voted);
      chk("mismatch", int'(mismatch), m_mis);
      chk("uncorrectable", int'(uncorrectable), m_unc);
      chk("err_count_a", int'(err_count_a), m_cnt[0]);
      chk("err_count_b", int'(err_count_b), m_cnt[1]);
      chk("err_count_c", int'(err_count_c), m_cnt[2]);
      chk("faulty", int'(faulty), (int'(m_flt[2]) << 2) | (int'(m_flt[1]) << 1) | int'(m_flt[0]));
      chk("scrub_req", int'(scrub_req), int'(m_req));
      chk("scrub_sel", int'(scrub_sel), (m_sel >= 0) ? (1 << m_sel) : 0);
    end
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic en, input logic clr, input logic ack);
    rep_a = a; rep_b = b; rep_c = c;
    enable = en; clr_counts = clr; scrub_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] base, m1, m2;
    int r, bad_rep;
    model_reset();
    chk_on = 1'b1;
    repeat (2) tick();
    chk("reset_voted", int'(voted_out), 0);
    chk("reset_req", int'(scrub_req), 0);
    chk("reset_faulty", int'(faulty), 0);
    @(negedge clk);
    rst = 1'b1;

    // Agreeing replicas
    drive(4'b0110, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t1_voted", int'(voted_out), 6);
    chk("t1_mismatch", int'(mismatch), 0);
    chk("t1_req", int'(scrub_req), 0);

    // Single-cycle upset on C
    drive(4'b0110, 4'b0110, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t2_voted", int'(voted_out), 6);
    chk("t2_mismatch", int'(mismatch), 4);
    chk("t2_cnt_c", int'(err_count_c), 1);
    chk("t2_faulty", int'(faulty), 0);

    // Persistent fault on B and its scrub
    drive(4'b0111, 4'b0011, 4'b0111, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("t3_faulty", int'(faulty), 2);
    chk("t3_req_early", int'(scrub_req), 0);
    drive(4'b0111, 4'b0111, 4'b0111, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t3_req", int'(scrub_req), 1);
    chk("t3_sel", int'(scrub_sel), 2);
    drive(4'b0111, 4'b0111, 4'b0111, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t3_done_req", int'(scrub_req), 0);
    drive(4'b0111, 4'b0111, 4'b0111, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t3_faulty_clr", int'(faulty), 0);
    chk("t3_cnt_b", int'(err_count_b), 3);

    // All three replicas disagree
    drive(4'b0001, 4'b0010, 4'b0100, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t4_voted", int'(voted_out), 0);
    chk("t4_uncorr", int'(uncorrectable), 1);
    chk("t4_mismatch", int'(mismatch), 7);
    repeat (4) tick();
    chk("t4_faulty", int'(faulty), 7);
    chk("t4_req", int'(scrub_req), 0);

    // Counter saturation and clear priority
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t5_clr_faulty", int'(faulty), 0);
    drive(4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (255) tick();
    chk("t5_sat", int'(err_count_a), 255);
    repeat (5) tick();
    chk("t5_sat_hold", int'(err_count_a), 255);
    chk("t5_req", int'(scrub_req), 1);
    chk("t5_sel", int'(scrub_sel), 1);
    drive(4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t5_clr_cnt", int'(err_count_a), 0);
    chk("t5_clr_flt", int'(faulty), 0);
    chk("t5_req_held", int'(scrub_req), 1);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick();

    // Asynchronous reset during a handshake
    drive(4'b0101, 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    drive(4'b0101, 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t6_req", int'(scrub_req), 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_async_req", int'(scrub_req), 0);
    chk("t6_async_voted", int'(voted_out), 0);
    chk("t6_async_cnt_c", int'(err_count_c), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t6_idle_req", int'(scrub_req), 0);
    chk("t6_idle_sel", int'(scrub_sel), 0);

    // Randomized traffic
    bad_rep = 0;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 20) == 0) bad_rep = $urandom_range(0, 2);
      base = 4'($urandom_range(0, 15));
      rep_a = base; rep_b = base; rep_c = base;
      r = $urandom_range(0, 99);
      m1 = 4'($urandom_range(1, 15));
      if (r < 35) begin
        if (bad_rep == 0) rep_a = base ^ m1;
        else if (bad_rep == 1) rep_b = base ^ m1;
        else rep_c = base ^ m1;
      end else if (r < 42) begin
        m2 = (m1 == 4'd15) ? 4'd1 : m1 + 4'd1;
        rep_b = base ^ m1;
        rep_c = base ^ m2;
      end else if (r < 50) begin
        rep_a = 4'($urandom_range(0, 15));
        rep_b = 4'($urandom_range(0, 15));
        rep_c = 4'($urandom_range(0, 15));
      end
      enable     = ($urandom_range(0, 9) != 0);
      clr_counts = ($urandom_range(0, 99) == 0);
      scrub_ack  = ($urandom_range(0, 3) == 0);
      tick();
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
